// File: rtl/imem_boot_loader_if.sv
// Boot loader bus bundle: the incoming byte stream with its handshake, plus the
// instruction-memory write port it produces.
`timescale 1ns/1ps
interface imem_boot_loader_if #(
  parameter int AW = 8
);
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Packs a length-prefixed little-endian byte stream into 32-bit instruction-memory
// writes and keeps the core in reset until the whole image has landed.
`timescale 1ns/1ps
module imem_boot_loader #(
  parameter int IMEM_WORDS = 256,
  parameter int AW         = 8
) (
  input  logic              clk,
  input  logic              rst,
  imem_boot_loader_if.slave bus,
  input  logic              reload,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    DONE,
    ERR
  } state_t;

  localparam logic [15:0] MAX_N = 16'(IMEM_WORDS);

  state_t        state;
  state_t        state_next;
  logic [1:0]    byte_cnt;
  logic [AW-1:0] word_idx;
  logic [31:0]   word_buf;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [31:0]   wdata_q;
  logic          accept;
  logic [15:0]   n_full;
  logic          last_word;

  assign bus.in_ready   = rst & ((state == LEN_LO) | (state == LEN_HI) | (state == DATA));
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;

  assign accept    = bus.in_valid & bus.in_ready;
  assign n_full    = {bus.in_data, word_count[7:0]};
  assign last_word = ({{(16-AW){1'b0}}, word_idx} == (word_count - 16'd1));

  always_comb begin
    state_next = state;
    case (state)
      LEN_LO: if (accept) state_next = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (n_full == 16'd0)     state_next = DONE;
          else if (n_full > MAX_N) state_next = ERR;
          else                     state_next = DATA;
        end
      end
      DATA:     if (accept && (byte_cnt == 2'd3) && last_word) state_next = DONE;
      DONE, ERR: if (reload) state_next = LEN_LO;
      default:  state_next = LEN_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= LEN_LO;
      byte_cnt   <= 2'd0;
      word_idx   <= '0;
      word_count <= 16'd0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      cpu_rst    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state <= state_next;
      we_q  <= 1'b0;
      case (state)
        LEN_LO: if (accept) word_count[7:0] <= bus.in_data;
        LEN_HI: begin
          if (accept) begin
            word_count[15:8] <= bus.in_data;
            byte_cnt         <= 2'd0;
            word_idx         <= '0;
            if (state_next == ERR) error <= 1'b1;
          end
        end
        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            // The fourth byte bypasses word_buf so the write issues in the next cycle.
            if (byte_cnt == 2'd3) begin
              we_q     <= 1'b1;
              waddr_q  <= word_idx;
              wdata_q  <= {bus.in_data, word_buf[23:0]};
              word_idx <= word_idx + AW'(1);
            end
          end
        end
        DONE: begin
          if (reload) begin
            byte_cnt   <= 2'd0;
            word_idx   <= '0;
            word_count <= 16'd0;
            cpu_rst    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
          end else begin
            cpu_rst <= 1'b1;
            done    <= 1'b1;
          end
        end
        ERR: begin
          if (reload) begin
            byte_cnt   <= 2'd0;
            word_idx   <= '0;
            word_count <= 16'd0;
            cpu_rst    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Lane buffer needs no reset: byte_cnt restarting at 0 makes stale lanes unreachable.
  always_ff @(posedge clk) begin
    if (state == DATA && accept) word_buf[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: nominal, backpressure, length limits,
// mid-image reset and reload behaviour.
`timescale 1ns/1ps
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reload = 1'b0;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  wa[$];
  logic [31:0] wd[$];

  imem_boot_loader_if #(.AW(8)) bus ();

  imem_boot_loader #(.IMEM_WORDS(256), .AW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .reload     (reload),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wa.push_back(bus.imem_waddr);
      wd.push_back(bus.imem_wdata);
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one byte and returns just after the edge that accepts it.
  task automatic send(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    reload       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wa.delete();
    wd.delete();
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    bus.in_valid = 1'b0;
    reload       = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic run_nominal(input bit bp, input string tag);
    logic [7:0] img [10];
    img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h63, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) begin
      send(img[i]);
      if (bp && i < 9) idle((i == 3 || i == 7) ? 5 : 3);
    end
    idle(1);
    check({tag, "_cpu_rst_k"}, 32'(cpu_rst), 32'd0);
    check({tag, "_we_k"}, 32'(bus.imem_we), 32'd1);
    @(negedge clk);
    check({tag, "_cpu_rst_k1"}, 32'(cpu_rst), 32'd1);
    check({tag, "_done_k1"}, 32'(done), 32'd1);
    check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_pulses"}, 32'(wa.size()), 32'd2);
    check({tag, "_word_count"}, 32'(word_count), 32'd2);
    if (wa.size() >= 2) begin
      check({tag, "_addr0"}, 32'(wa[0]), 32'd0);
      check({tag, "_data0"}, wd[0], 32'h0050_0093);
      check({tag, "_addr1"}, 32'(wa[1]), 32'd1);
      check({tag, "_data1"}, wd[1], 32'h0000_0063);
    end
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_we", 32'(bus.imem_we), 32'd0);
    check("rst_wdata", bus.imem_wdata, 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_nominal(1'b0, "nom");

    // Reload from DONE, then a fresh one-word image
    pulse_reload();
    check("reload_cpu_rst", 32'(cpu_rst), 32'd0);
    check("reload_done", 32'(done), 32'd0);
    check("reload_in_ready", 32'(bus.in_ready), 32'd1);
    check("reload_word_count", 32'(word_count), 32'd0);
    wa.delete();
    wd.delete();
    send(8'h01); send(8'h00); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    idle(1);
    check("reload_img_cpu_rst_k", 32'(cpu_rst), 32'd0);
    @(negedge clk);
    check("reload_img_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reload_img_pulses", 32'(wa.size()), 32'd1);
    check("reload_img_addr", 32'(wa[0]), 32'd0);
    check("reload_img_data", wd[0], 32'hDEAD_BEEF);

    do_reset();
    run_nominal(1'b1, "bp");

    // N == 0
    do_reset();
    send(8'h00); send(8'h00);
    idle(1);
    check("n0_cpu_rst_k", 32'(cpu_rst), 32'd0);
    check("n0_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("n0_cpu_rst_k1", 32'(cpu_rst), 32'd1);
    check("n0_done", 32'(done), 32'd1);
    idle(3);
    check("n0_pulses", 32'(wa.size()), 32'd0);

    // N == 257 rejected
    do_reset();
    send(8'h01); send(8'h01);
    idle(1);
    check("n257_error", 32'(error), 32'd1);
    check("n257_in_ready", 32'(bus.in_ready), 32'd0);
    check("n257_word_count", 32'(word_count), 32'h0101);
    idle(3);
    check("n257_cpu_rst", 32'(cpu_rst), 32'd0);
    check("n257_pulses", 32'(wa.size()), 32'd0);
    pulse_reload();
    check("err_reload_error", 32'(error), 32'd0);
    check("err_reload_in_ready", 32'(bus.in_ready), 32'd1);

    // N == 256, full memory
    do_reset();
    send(8'h00); send(8'h01);
    for (int i = 0; i < 1024; i++) send(i[7:0]);
    idle(1);
    @(negedge clk);
    check("n256_error", 32'(error), 32'd0);
    check("n256_done", 32'(done), 32'd1);
    check("n256_pulses", 32'(wa.size()), 32'd256);
    if (wa.size() == 256) begin
      check("n256_data1", wd[1], 32'h0706_0504);
      check("n256_last_addr", 32'(wa[255]), 32'h0000_00FF);
      check("n256_last_data", wd[255], 32'hFFFE_FDFC);
    end

    // Reset in the middle of word 1
    do_reset();
    send(8'h02); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd0);
    check("midrst_wdata", bus.imem_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pulses", 32'(wa.size()), 32'd1);
    check("midrst_word_count", 32'(word_count), 32'd0);
    check("midrst_in_ready_after", 32'(bus.in_ready), 32'd1);
    wa.delete();
    wd.delete();
    send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(1);
    @(negedge clk);
    check("midrst_new_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_new_pulses", 32'(wa.size()), 32'd1);
    check("midrst_new_addr", 32'(wa[0]), 32'd0);
    check("midrst_new_data", wd[0], 32'h4433_2211);

    // Reload ignored while in DATA
    do_reset();
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    pulse_reload();
    check("data_reload_in_ready", 32'(bus.in_ready), 32'd1);
    check("data_reload_word_count", 32'(word_count), 32'd1);
    send(8'hCC); send(8'hDD);
    idle(1);
    @(negedge clk);
    check("data_reload_done", 32'(done), 32'd1);
    check("data_reload_pulses", 32'(wa.size()), 32'd1);
    check("data_reload_data", wd[0], 32'hDDCC_BBAA);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
